uart_io_control: RTL
====================

Name: uart_io_control

Overview:
- Parametrised successor of the single-channel send-opcode pulser.
- Decodes both SND and RCV opcodes in the execute stage and targets one of N_CH UART channels.
- Waits for the selected channel to be ready, then issues exactly one registered one-cycle pulse per instruction assertion.
- Stalls the CPU while waiting and aborts with a sticky timeout flag if the channel never becomes ready.
- Sits between the control unit and the UART TX/RX blocks.

Parameters:
OPC_W, 6, opcode width
OPCODE_SND, 6'b010001, send opcode
OPCODE_RCV, 6'b010010, receive opcode
CH_W, 2, channel-select width; N_CH = 2**CH_W channels
TIMEOUT, 1024, max cycles spent waiting for ready/valid; 0 disables the timeout
TO_W, 16, timeout counter width; TIMEOUT must be < 2**TO_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  OPC_W  current instruction opcode
ch_sel  in  CH_W  target channel from instruction field
input_sig_snd  in  1  execute-stage qualifier; level, held for the instruction's duration
tx_ready  in  N_CH  per-channel TX idle/ready
rx_valid  in  N_CH  per-channel RX byte available
snd_flag  out  N_CH  one-hot, one-cycle TX start pulse
rcv_ack  out  N_CH  one-hot, one-cycle RX pop pulse
stall  out  1  hold PC/pipeline
timeout  out  1  sticky: last request aborted on timeout

Behaviour:
- Reset (async, immediate): state=IDLE, armed=1, counter=0; snd_flag, rcv_ack, stall and timeout all 0.
- req = input_sig_snd & armed & (opcode==OPCODE_SND | opcode==OPCODE_RCV).
- stall is combinational: req in IDLE, or state in {WAIT, PULSE}.
  - stall rises in the same cycle the request appears.
  - stall is low in HOLD.
- IDLE:
  - On req, latch op (SND/RCV) and ch_sel, clear timeout and counter, clear armed, go to WAIT.
  - Later changes to opcode and ch_sel are ignored until IDLE is reached again.
- WAIT:
  - cond = tx_ready[ch] for SND, rx_valid[ch] for RCV.
  - cond=1 -> go to PULSE.
  - else if TIMEOUT!=0 and counter==TIMEOUT-1 -> set timeout=1, go to HOLD with no pulse.
  - else counter+1.
  - input_sig_snd=0 in WAIT -> abort to IDLE with no pulse, timeout unchanged, armed=1.
- PULSE (one cycle):
  - Registered output: snd_flag[ch]=1 (SND) or rcv_ack[ch]=1 (RCV); all other bits 0.
  - Then go to HOLD.
- HOLD:
  - Wait for input_sig_snd=0, then set armed=1 and go to IDLE.
  - Guarantees one transfer per assertion, even if the opcode stays SND/RCV across many cycles.
- Latency: req sampled at edge k; ready already high gives the pulse in the cycle after edge k+1, i.e. 2 cycles from the request.
- Pulse width is exactly 1 cycle; at most one bit of snd_flag|rcv_ack is high at any time.
- A ready/valid drop after PULSE is irrelevant; the transfer is committed.
- Back-to-back instructions: the qualifier must go low ≥1 cycle between them. A continuously high qualifier with a changed opcode does not re-fire.
- Counter saturates and never wraps.
- Reset asserted mid-WAIT or mid-PULSE kills the pulse immediately. After reset release with input_sig_snd still high, a new request is accepted (armed=1).

Test Plan:
- SND ch=2, tx_ready=4'b0100 constant, qualifier high 10 cycles -> snd_flag=4'b0100 for exactly one cycle, 2 cycles after request. stall high 3 cycles, then low. No second pulse.
- RCV ch=1, rx_valid[1] rises 5 cycles after request -> rcv_ack=4'b0010 one cycle after rx_valid is seen. stall high throughout. snd_flag stays 0.
- TIMEOUT=8, SND ch=0, tx_ready=0 -> after 8 WAIT cycles: timeout=1, stall=0, no pulse. Next request clears timeout at acceptance.
- Qualifier drops in WAIT (ch=3, ready low) -> IDLE, no pulse. Reassert with ready=1 -> single pulse on ch3.
- ch_sel changes from 1 to 3 during WAIT -> pulse lands on bit 1 only. Non-I/O opcode with qualifier high -> no stall, no pulse.
- Assert reset during PULSE -> all outputs 0 asynchronously. Release with qualifier and SND still high -> a fresh pulse is issued 2 cycles later.

Source files
------------

// File: rtl/uart_io_control.sv
// Execute-stage UART request sequencer: decodes SND/RCV opcodes, waits for the chosen
// channel, and fires one registered pulse per qualifier assertion, with stall and timeout.
module uart_io_control #(
   parameter int               OPC_W      = 6,
   parameter logic [OPC_W-1:0] OPCODE_SND = 6'b010001,
   parameter logic [OPC_W-1:0] OPCODE_RCV = 6'b010010,
   parameter int               CH_W       = 2,
   parameter int               TIMEOUT    = 1024,
   parameter int               TO_W       = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [OPC_W-1:0]     opcode,
   input  logic [CH_W-1:0]      ch_sel,
   input  logic                 input_sig_snd,
   input  logic [(2**CH_W)-1:0] tx_ready,
   input  logic [(2**CH_W)-1:0] rx_valid,
   output logic [(2**CH_W)-1:0] snd_flag,
   output logic [(2**CH_W)-1:0] rcv_ack,
   output logic                 stall,
   output logic                 timeout
);

   localparam int N_CH = 2**CH_W;

   typedef enum logic [1:0] {IDLE, WAIT, PULSE, HOLD} state_t;

   state_t            state, state_nxt;
   logic              armed, armed_nxt;
   logic [TO_W-1:0]   counter, counter_nxt;
   logic              op_rcv, op_rcv_nxt;
   logic [CH_W-1:0]   ch, ch_nxt;
   logic              timeout_nxt;
   logic [N_CH-1:0]   snd_nxt, rcv_nxt;
   logic              is_io, req, cond, timeout_hit;

   assign is_io       = (opcode == OPCODE_SND) || (opcode == OPCODE_RCV);
   assign req         = input_sig_snd && armed && is_io;
   assign cond        = op_rcv ? rx_valid[ch] : tx_ready[ch];
   assign timeout_hit = (TIMEOUT != 0) && (counter == TO_W'(TIMEOUT - 1));

   // Stall is forced low while reset is held so every output reads zero during reset.
   assign stall = !reset && (((state == IDLE) && req) || (state == WAIT) || (state == PULSE));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         armed    <= 1'b1;
         counter  <= '0;
         op_rcv   <= 1'b0;
         ch       <= '0;
         timeout  <= 1'b0;
         snd_flag <= '0;
         rcv_ack  <= '0;
      end else begin
         state    <= state_nxt;
         armed    <= armed_nxt;
         counter  <= counter_nxt;
         op_rcv   <= op_rcv_nxt;
         ch       <= ch_nxt;
         timeout  <= timeout_nxt;
         snd_flag <= snd_nxt;
         rcv_ack  <= rcv_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      armed_nxt   = armed;
      counter_nxt = counter;
      op_rcv_nxt  = op_rcv;
      ch_nxt      = ch;
      timeout_nxt = timeout;
      snd_nxt     = '0;
      rcv_nxt     = '0;
      case (state)
         IDLE: begin
            if (req) begin
               op_rcv_nxt  = (opcode == OPCODE_RCV);
               ch_nxt      = ch_sel;
               timeout_nxt = 1'b0;
               counter_nxt = '0;
               armed_nxt   = 1'b0;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            // A dropped qualifier wins over a ready channel: the instruction is gone.
            if (!input_sig_snd) begin
               armed_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (cond) begin
               if (op_rcv) rcv_nxt = N_CH'(1) << ch;
               else        snd_nxt = N_CH'(1) << ch;
               state_nxt = PULSE;
            end else if (timeout_hit) begin
               timeout_nxt = 1'b1;
               state_nxt   = HOLD;
            end else if (counter != '1) begin
               counter_nxt = counter + 1'b1;
            end
         end
         PULSE: state_nxt = HOLD;
         HOLD: begin
            if (!input_sig_snd) begin
               armed_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
